// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add sequencer.
// Adds two WORDS*N-bit operands one N-bit slice per cycle through a single
// N-bit adder, with the carry rippling between slices through a register.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only in IDLE)
//   a, b, c_in, sub     operands, carry-in, subtract request (latched on accept)
//   out_valid/out_ready result handshake (valid only in DONE)
//   z, c_out            registered sum and final carry
//   busy                high while an operation is in RUN or DONE
//
// Configuration macro: MP_ADD_SUB_EN
//   defined   -> sub=1 computes a + ~b + 1 (c_out=1 means no borrow)
//   undefined -> sub is ignored; result is always a + b + c_in

// N-bit ripple slice adder shared by the sequencer.
module adder #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         c_i,
    output logic [N-1:0] z_o,
    output logic         c_o
);
    assign {c_o, z_o} = (N+1)'(a_i) + (N+1)'(b_i) + (N+1)'(c_i);
endmodule

module mp_add_seq #(
    parameter int unsigned N     = 32,
    parameter int unsigned WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    input  logic               c_in,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WORDS-1:0] z,
    output logic               c_out,
    output logic               busy
);
    localparam int unsigned W  = N * WORDS;
    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            cy_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    z_q;
    logic            c_out_q;

    logic [N-1:0]    a_sl;
    logic [N-1:0]    b_sl;
    logic [N-1:0]    sum_d;
    logic            carry_d;
    logic [W-1:0]    b_acc_d;
    logic            cy_acc_d;

    // Operand B and initial carry as captured on accept.
`ifdef MP_ADD_SUB_EN
    assign b_acc_d  = sub ? ~b : b;
    assign cy_acc_d = sub ? 1'b1 : c_in;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign b_acc_d    = b;
    assign cy_acc_d   = c_in;
`endif

    // Select the active slice of the latched operands.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < int'(WORDS); i++) begin
            if (idx_q == IW'(i)) begin
                a_sl = a_q[i*N +: N];
                b_sl = b_q[i*N +: N];
            end
        end
    end

    adder #(.N(N)) u_adder (
        .a_i (a_sl),
        .b_i (b_sl),
        .c_i (cy_q),
        .z_o (sum_d),
        .c_o (carry_d)
    );

    // Sequencer FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            z_q     <= '0;
            c_out_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_acc_d;
                        cy_q    <= cy_acc_d;
                        idx_q   <= '0;
                        z_q     <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < int'(WORDS); i++) begin
                        if (idx_q == IW'(i)) begin
                            z_q[i*N +: N] <= sum_d;
                        end
                    end
                    cy_q  <= carry_d;
                    idx_q <= idx_q + IW'(1);
                    if (idx_q == IW'(WORDS - 1)) begin
                        c_out_q <= carry_d;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from the state register.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign z         = z_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_mp_add_seq.sv
module tb_mp_add_seq;
    localparam int unsigned N     = 32;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = N * WORDS;
    localparam logic [W-1:0] ONES = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         c_out;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    mp_add_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference: wide unsigned arithmetic, {carry, sum}.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
`ifdef MP_ADD_SUB_EN
        if (ms) begin
            logic [W-1:0] diff;
            diff = ma - mb;
            return {(ma >= mb), diff};
        end
`endif
        return {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
    endfunction

    // Random operand with slices biased toward 0 / all ones to exercise carries.
    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(WORDS); k++) begin
            case ($urandom_range(0, 3))
                0:       r[k*N +: N] = '0;
                1:       r[k*N +: N] = '1;
                default: r[k*N +: N] = N'($urandom);
            endcase
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one full transaction from IDLE; returns latency, result, carry.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts,
                          output int lat, output logic [W-1:0] oz, output logic oc);
        in_valid = 1'b1; a = ta; b = tb_v; c_in = tc; sub = ts;
        step();
        in_valid = 1'b0; a = rand_w(); b = rand_w();
        c_in = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            step();
            lat++;
        end
        oz = z; oc = c_out;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, busy, c_out} !== 4'b0100 || z !== '0) begin
            failures++;
            $display("FAIL reset: out_valid=%b in_ready=%b busy=%b c_out=%b z=%h, want 0 1 0 0 0",
                     out_valid, in_ready, busy, c_out, z);
        end
    endtask

    task automatic test_cross_carry();
        int lat; logic [W-1:0] rz; logic rc;
        logic [W-1:0] exp_z;
        exp_z = 128'h00000000_00000000_00000001_00000000;
        run_op(128'h00000000_00000000_00000000_FFFFFFFF, 128'd1, 1'b0, 1'b0, lat, rz, rc);
        checks++;
        if (lat !== int'(WORDS)) begin
            failures++;
            $display("FAIL cross_latency: got %0d want %0d", lat, WORDS);
        end
        checks++;
        if (rz !== exp_z || rc !== 1'b0) begin
            failures++;
            $display("FAIL cross_carry: got z=%h c=%b want z=%h c=0", rz, rc, exp_z);
        end
    endtask

    task automatic test_full_ripple();
        int lat; logic [W-1:0] rz; logic rc;
        run_op(ONES, '0, 1'b1, 1'b0, lat, rz, rc);
        checks++;
        if (rz !== '0 || rc !== 1'b1) begin
            failures++;
            $display("FAIL ripple_ones_plus_cin: got z=%h c=%b want z=0 c=1", rz, rc);
        end
        run_op(ONES, ONES, 1'b1, 1'b0, lat, rz, rc);
        checks++;
        if (rz !== ONES || rc !== 1'b1) begin
            failures++;
            $display("FAIL ripple_ones_ones_cin: got z=%h c=%b want z=%h c=1", rz, rc, ONES);
        end
    endtask

    task automatic test_subtract();
        int lat; logic [W-1:0] rz; logic rc;
        logic [W-1:0] exp_z;
`ifdef MP_ADD_SUB_EN
        exp_z = ONES - 128'd1;
`else
        exp_z = 128'd12;
`endif
        run_op(128'd5, 128'd7, 1'b0, 1'b1, lat, rz, rc);
        checks++;
        if (rz !== exp_z || rc !== 1'b0) begin
            failures++;
            $display("FAIL sub_5_7: got z=%h c=%b want z=%h c=0", rz, rc, exp_z);
        end
`ifdef MP_ADD_SUB_EN
        run_op(128'd7, 128'd5, 1'b0, 1'b1, lat, rz, rc);
        checks++;
        if (rz !== 128'd2 || rc !== 1'b1) begin
            failures++;
            $display("FAIL sub_7_5: got z=%h c=%b want z=2 c=1", rz, rc);
        end
`endif
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] rz; logic rc;
        logic [W-1:0] ra, rb; logic rci, rs; logic [W:0] exp;
        for (int t = 0; t < 20; t++) begin
            ra = rand_w(); rb = rand_w(); rci = 1'($urandom); rs = 1'($urandom);
            exp = model(ra, rb, rci, rs);
            run_op(ra, rb, rci, rs, lat, rz, rc);
            checks++;
            if ({rc, rz} !== exp || lat !== int'(WORDS)) begin
                failures++;
                $display("FAIL random[%0d]: a=%h b=%h cin=%b sub=%b got c=%b z=%h lat=%0d want c=%b z=%h lat=%0d",
                         t, ra, rb, rci, rs, rc, rz, lat, exp[W], exp[W-1:0], WORDS);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [W-1:0] a1, b1, a2, b2, hz; logic hc; logic [W:0] exp; int lat; bit bad;
        a1 = rand_w(); b1 = rand_w(); a2 = rand_w(); b2 = rand_w();
        in_valid = 1'b1; a = a1; b = b1; c_in = 1'b0; sub = 1'b0;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin step(); lat++; end
        hz = z; hc = c_out;
        exp = model(a1, b1, 1'b0, 1'b0);
        checks++;
        if ({hc, hz} !== exp) begin
            failures++;
            $display("FAIL bp_first_result: got c=%b z=%h want c=%b z=%h", hc, hz, exp[W], exp[W-1:0]);
        end
        in_valid = 1'b1; a = a2; b = b2; c_in = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || z !== hz || c_out !== hc) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL bp_hold: got out_valid=%b in_ready=%b z=%h c=%b want 1 0 %h %b",
                     out_valid, in_ready, z, c_out, hz, hc);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept_next: got busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin step(); lat++; end
        exp = model(a2, b2, 1'b1, 1'b0);
        checks++;
        if ({c_out, z} !== exp || lat !== int'(WORDS)) begin
            failures++;
            $display("FAIL bp_second_result: got c=%b z=%h lat=%0d want c=%b z=%h lat=%0d",
                     c_out, z, lat, exp[W], exp[W-1:0], WORDS);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat; logic [W-1:0] rz; logic rc; bit seen;
        run_op(ONES, '0, 1'b1, 1'b0, lat, rz, rc);
        in_valid = 1'b1; a = rand_w() | 128'h1; b = ONES; c_in = 1'b1; sub = 1'b0;
        step();
        in_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || z !== '0 || c_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: got in_ready=%b busy=%b out_valid=%b z=%h c=%b want 1 0 0 0 0",
                     in_ready, busy, out_valid, z, c_out);
        end
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_mid_no_valid: got out_valid pulse=1 want 0");
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] expq[$];
        int acc[$];
        logic [W:0] e;
        int results = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        a = rand_w(); b = rand_w(); c_in = 1'($urandom); sub = 1'($urandom);
        for (int cyc = 0; cyc < 40; cyc++) begin
            bit took;
            took = 0;
            if (in_ready === 1'b1) begin
                expq.push_back(model(a, b, c_in, sub));
                acc.push_back(cyc);
                took = 1;
            end
            if (out_valid === 1'b1) begin
                e = (expq.size() > 0) ? expq.pop_front() : '0;
                results++;
                checks++;
                if ({c_out, z} !== e) begin
                    failures++;
                    $display("FAIL b2b_result[%0d]: got c=%b z=%h want c=%b z=%h",
                             results, c_out, z, e[W], e[W-1:0]);
                end
            end
            step();
            if (took) begin
                a = rand_w(); b = rand_w(); c_in = 1'($urandom); sub = 1'($urandom);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 1; k < acc.size(); k++) begin
            checks++;
            if (acc[k] - acc[k-1] != int'(WORDS) + 2) begin
                failures++;
                $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, acc[k] - acc[k-1], WORDS + 2);
            end
        end
        checks++;
        if (results < 5) begin
            failures++;
            $display("FAIL b2b_count: got %0d results want >= 5", results);
        end
        // Drain any in-flight operation.
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        #1;
        test_reset();
        test_cross_carry();
        test_full_ripple();
        test_subtract();
        test_random();
        test_back_pressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mp_add_seq.md
# mp_add_seq

Multi-precision add sequencer. It accepts two wide operands of WORDS×N bits and computes their sum over WORDS cycles. Internally it instantiates one N-bit `adder` and chains the carry through a register between word slices. It sits between the datapath issue logic and the shared N-bit adder, so wide additions can be done without a WORDS×N-bit carry-lookahead tree.

## Interface
- N, 32, adder slice width; power of two, ≥2 (constraint of `adder`/`add_nb`)
- WORDS, 4, number of N-bit slices per operand; ≥1
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  request accepted when in_valid & in_ready at a rising edge
- a  input  N*WORDS  operand A; slice i = a[i*N +: N]
- b  input  N*WORDS  operand B
- c_in  input  1  initial carry-in
- sub  input  1  subtract request; see Configuration
- out_valid  output  1  result available
- out_ready  input  1  result consumed when out_valid & out_ready at a rising edge
- z  output  N*WORDS  registered sum
- c_out  output  1  registered final carry
- busy  output  1  high in RUN or DONE

## Operation
- FSM states: IDLE, RUN, DONE. Slice index idx is ⌈log2 WORDS⌉ bits wide, minimum 1. Carry register cy.
- IDLE: in_ready=1. On accept:
  - latch a, b (or ~b), sub.
  - cy ← c_in, or 1 when subtracting.
  - idx ← 0, z ← 0, state ← RUN.
- RUN: in_ready=0. Adder inputs are a_reg/b_reg slice idx and cy. Each edge:
  - z slice idx ← adder z.
  - cy ← adder c_out.
  - idx ← idx+1.
  - When idx==WORDS-1: c_out ← adder c_out and state ← DONE.
- DONE: out_valid=1; z and c_out are held stable. On out_ready, state ← IDLE.
- Arithmetic is unsigned modulo 2^(N*WORDS). c_out is bit N*WORDS of a + b + c_in.
- Operands are latched at accept, so a, b, c_in and sub may change freely afterwards.
- in_valid outside IDLE is ignored (not queued). out_ready outside DONE is ignored.
- Reset at any time, including mid-RUN or in DONE, aborts the operation. No out_valid is produced for it.
- Reset values:
  - state=IDLE, idx=0, cy=0.
  - z=0, c_out=0.
  - out_valid=0, in_ready=1, busy=0.

## Timing
- Accept at edge k. RUN occupies edges k+1…k+WORDS. out_valid is high starting the cycle after edge k+WORDS.
- Latency from the accept edge to out_valid is WORDS edges. WORDS=1 gives a single RUN cycle.
- Earliest next accept is the edge after the consuming edge, since in_ready is high only in IDLE. Sustained throughput is one result per WORDS+2 cycles.
- in_ready, out_valid and busy decode directly from the state register, with no combinational path from in_valid or out_ready.
- Critical path: one N-bit `adder` plus slice muxing. No path spans more than one slice.

## Configuration
- MP_ADD_SUB_EN defined:
  - sub=1 at accept computes a + ~b + 1 (that is, a − b); c_in is ignored.
  - c_out=1 means no borrow.
- MP_ADD_SUB_EN undefined:
  - The sub port exists but is ignored and treated as 0; no inverter logic is built.
  - The result is always a + b + c_in.

## Test plan
- Reset then idle: after rst, out_valid=0, in_ready=1, busy=0, z=0, c_out=0.
- Cross-slice carry (N=32, WORDS=4): a=0x00000000_00000000_00000000_FFFFFFFF, b=1, c_in=0.
  - Expect z=0x00000000_00000000_00000001_00000000 and c_out=0.
  - out_valid rises exactly 4 edges after accept.
- Full ripple:
  - a=all ones, b=0, c_in=1 → z=0, c_out=1.
  - a=b=all ones, c_in=1 → z=all ones, c_out=1.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 and new operands.
  - z, c_out and out_valid stay stable; in_ready stays 0; the new operands are not taken.
  - Release out_ready: one cycle later in_ready=1, and the new operands are accepted on the next edge.
- Reset mid-operation: assert rst for 1 cycle while idx=2.
  - Next cycle: state IDLE, z=0, c_out=0, in_ready=1.
  - out_valid never pulses for the aborted operation.
- Subtract (a=5, b=7, sub=1, c_in=0):
  - With MP_ADD_SUB_EN: z=2^128−2, c_out=0.
  - Without it: z=12, c_out=0.
  - With MP_ADD_SUB_EN, a=7, b=5: z=2, c_out=1.
